// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline that packs an immediate into an instruction template (I/S/B/U).
// Define IMM_RANGE_CHECK_EN to flag immediates that do not fit the selected format on out_err.
module imm_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_tmpl,
   input  logic [31:0] in_imm,
   input  logic [1:0]  in_fmt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err,
   output logic [15:0] enc_count
);

   typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_U = 2'b11} fmt_e;

   logic        s1_valid_q, s1_valid_d;
   logic [31:0] s1_tmpl_q, s1_tmpl_d;
   logic [31:0] s1_imm_q, s1_imm_d;
   fmt_e        s1_fmt_q, s1_fmt_d;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        out_err_q, out_err_d;
   logic [15:0] enc_count_q, enc_count_d;

   logic        s2_adv, s1_move, in_fire, out_fire;
   logic [31:0] packed_word;
   logic        range_err;

   // Handshakes are suppressed while reset is high so a reset cycle never transfers a word.
   always_comb begin
      s2_adv    = !s2_valid_q || out_ready;
      s1_move   = s1_valid_q && s2_adv;
      in_ready  = !reset && (!s1_valid_q || s2_adv);
      out_valid = s2_valid_q && !reset;
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
   end

   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      packed_word = s1_tmpl_q;
      case (s1_fmt_q)
         FMT_I: packed_word[31:20] = s1_imm_q[11:0];
         FMT_S: begin
            packed_word[31:25] = s1_imm_q[11:5];
            packed_word[11:7]  = s1_imm_q[4:0];
         end
         FMT_B: begin
            packed_word[31]    = s1_imm_q[12];
            packed_word[30:25] = s1_imm_q[10:5];
            packed_word[11:8]  = s1_imm_q[4:1];
            packed_word[7]     = s1_imm_q[11];
         end
         default: packed_word[31:12] = s1_imm_q[31:12];
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // Sign-extension test: the bits above the field must all match the field's sign bit.
   always_comb begin
      range_err = 1'b0;
      case (s1_fmt_q)
         FMT_I, FMT_S: range_err = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
         FMT_B:        range_err = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) || s1_imm_q[0];
         default:      range_err = |s1_imm_q[11:0];
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_tmpl_d   = s1_tmpl_q;
      s1_imm_d    = s1_imm_q;
      s1_fmt_d    = s1_fmt_q;
      s2_valid_d  = s2_valid_q;
      out_instr_d = out_instr_q;
      out_err_d   = out_err_q;
      enc_count_d = enc_count_q + {15'd0, out_fire};

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_tmpl_d  = in_tmpl;
         s1_imm_d   = in_imm;
         s1_fmt_d   = fmt_e'(in_fmt);
      end else if (s1_move) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) s2_valid_d = s1_valid_q;
      if (s1_move) begin
         out_instr_d = packed_word;
         out_err_d   = range_err;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_instr_q <= 32'd0;
         out_err_q   <= 1'b0;
         enc_count_q <= 16'd0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         out_instr_q <= out_instr_d;
         out_err_q   <= out_err_d;
         enc_count_q <= enc_count_d;
      end
   end

   // NOTE: S1 payload is not reset; s1_valid_q alone decides whether it means anything.
   always_ff @(posedge clk) begin
      s1_tmpl_q <= s1_tmpl_d;
      s1_imm_q  <= s1_imm_d;
      s1_fmt_q  <= s1_fmt_d;
   end

   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign enc_count = enc_count_q;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream request valid.
REQ-004 SHALL have port in_ready, output, 1, encoder can accept this cycle.
REQ-005 SHALL have port in_tmpl, input, 32, instruction template; opcode/rd/rs/funct fields are taken from here.
REQ-006 SHALL have port in_imm, input, 32, immediate value, two's complement.
REQ-007 SHALL have port in_fmt, input, 2, format: 00=I, 01=S, 10=B, 11=U.
REQ-008 SHALL have port out_valid, output, 1, encoded word valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts.
REQ-010 SHALL have port out_instr, output, 32, encoded instruction.
REQ-011 SHALL have port out_err, output, 1, immediate not representable in the selected format.
REQ-012 SHALL have port enc_count, output, 16, count of completed output handshakes.

Function
REQ-013 SHALL use two register stages: S1 captures inputs; S2 holds the packed word and error flag.
REQ-014 SHALL accept input when in_valid && in_ready; output completes when out_valid && out_ready.
REQ-015 SHALL let S2 advance when !s2_valid || out_ready, and S1 move into S2 when s1_valid and S2 advances.
REQ-016 SHALL drive in_ready = !s1_valid || S2 advances; a combinational out_ready->in_ready path is allowed.
REQ-017 SHALL give a latency of 2 cycles from accept to out_valid with no stall; full throughput is 1 word per cycle.
REQ-018 SHALL keep out_instr and out_err stable while out_valid && !out_ready; no word is dropped, duplicated or reordered.
REQ-019 SHALL copy every in_tmpl bit not listed in REQ-020 to REQ-023 unchanged.
REQ-020 SHALL pack I format as instr[31:20]=imm[11:0].
REQ-021 SHALL pack S format as instr[31:25]=imm[11:5] and instr[11:7]=imm[4:0].
REQ-022 SHALL pack B format as instr[31]=imm[12], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1], instr[7]=imm[11]; imm[0] is discarded.
REQ-023 SHALL pack U format as instr[31:12]=imm[31:12].
REQ-024 SHALL truncate unrepresentable immediates in the packed word; out_err flags them.
REQ-025 SHALL increment enc_count by 1 per output handshake and wrap from 0xFFFF to 0x0000.
REQ-026 SHALL keep S2 content when simultaneous input accept and output handshake occur: S1→S2 transfer and new S1 capture happen in the same cycle.

Reset
REQ-027 SHALL clear on reset: s1_valid=0, out_valid=0, out_instr=0x00000000, out_err=0 and enc_count=0.
REQ-028 SHALL discard in-flight words on reset mid-operation, with in_ready=1 on the first cycle after reset deasserts.
REQ-029 SHALL block any handshake during a reset cycle and leave enc_count unchanged by it.

Configuration
REQ-030 SHALL, when IMM_RANGE_CHECK_EN is defined, set out_err=1 when any of these holds: I/S imm[31:11] not all equal; B imm[31:12] not all equal or imm[0]=1; U imm[11:0]!=0.
REQ-031 SHALL, when IMM_RANGE_CHECK_EN is undefined, tie out_err to 0 and synthesise no range-check logic.

Verification
REQ-032 SHALL cover I format: tmpl=0x00000013, imm=0xFFFFFFFF, fmt=00 -> out_instr=0xFFF00013, out_err=0, 2 cycles after accept.
REQ-033 SHALL cover S format: tmpl=0x00002023, imm=0x00000025, fmt=01 -> out_instr=0x020022A3, out_err=0.
REQ-034 SHALL cover B format: tmpl=0x00000063, imm=0xFFFFFFFE, fmt=10 -> out_instr=0xFE000FE3. With imm=0x00000003, out_err=1 only with IMM_RANGE_CHECK_EN.
REQ-035 SHALL cover I overflow: tmpl=0x00000013, imm=0x00000800, fmt=00 -> out_instr=0x80000013, out_err=1 with IMM_RANGE_CHECK_EN, else 0.
REQ-036 SHALL cover backpressure: out_ready=0 while 3 words are offered -> 2 accepted, then in_ready=0, out_instr stable. After out_ready=1, all 3 emit in order and enc_count=3.
REQ-037 SHALL cover reset mid-operation: reset asserted with S1 and S2 full -> next cycle out_valid=0, enc_count=0, in_ready=1, and no stale word emitted.
